// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : core_seq_ctrl
// Multi-cycle IF/ID/EX/MEM/WB sequencer for an RV32I core, with illegal-opcode
// and memory-timeout traps.
// Rev    : 1.0
// ============================================================================
module core_seq_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [6:0]           opcode,
    input  logic                 br_taken,
    output logic                 imem_req,
    input  logic                 imem_valid,
    output logic                 ir_we,
    output logic [2:0]           imm_sel,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] retire_cnt,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    input  logic                 trap_clr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_IF = 3'd1, S_ID = 3'd2, S_EX = 3'd3,
        S_MEM  = 3'd4, S_WB = 3'd5, S_TRAP = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_ALU = 3'd0, K_JUMP = 3'd1, K_LOAD = 3'd2,
        K_STORE = 3'd3, K_BRANCH = 3'd4, K_FENCE = 3'd5
    } kind_t;

    localparam logic [7:0] TMO_LIMIT  = 8'(TIMEOUT_CYC);
    localparam logic [1:0] CAUSE_ILL  = 2'd1;
    localparam logic [1:0] CAUSE_IMEM = 2'd2;
    localparam logic [1:0] CAUSE_DMEM = 2'd3;

    state_t                 state_q, state_d;
    kind_t                  kind_q, kind_d, dec_kind;
    logic [2:0]             imm_q, imm_d, dec_imm;
    logic                   dec_legal;
    logic [7:0]             tmo_q, tmo_d, tmo_inc;
    logic [1:0]             cause_q, cause_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    always_comb begin
        dec_legal = 1'b1;
        dec_kind  = K_ALU;
        dec_imm   = 3'd0;
        case (opcode)
            7'b0000011: begin dec_kind = K_LOAD;   dec_imm = 3'd1; end
            7'b0010011: begin dec_kind = K_ALU;    dec_imm = 3'd1; end
            7'b1100111: begin dec_kind = K_JUMP;   dec_imm = 3'd1; end
            7'b0100011: begin dec_kind = K_STORE;  dec_imm = 3'd2; end
            7'b1100011: begin dec_kind = K_BRANCH; dec_imm = 3'd3; end
            7'b0110111,
            7'b0010111: begin dec_kind = K_ALU;    dec_imm = 3'd4; end
            7'b1101111: begin dec_kind = K_JUMP;   dec_imm = 3'd5; end
            7'b0110011: begin dec_kind = K_ALU;    dec_imm = 3'd0; end
            7'b0001111: begin dec_kind = K_FENCE;  dec_imm = 3'd0; end
            default:    dec_legal = 1'b0;
        endcase
    end

    assign tmo_inc = tmo_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        imm_d    = imm_q;
        tmo_d    = '0;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'd0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        retire   = 1'b0;
        trap     = 1'b0;
        case (state_q)
            S_IDLE: if (en) state_d = S_IF;
            S_IF: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_we   = 1'b1;
                    state_d = S_ID;
                end else if (tmo_inc == TMO_LIMIT) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_IMEM;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_ID: begin
                if (dec_legal) begin
                    kind_d  = dec_kind;
                    imm_d   = dec_imm;
                    state_d = S_EX;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILL;
                end
            end
            S_EX: begin
                case (kind_q)
                    K_BRANCH: begin pc_we = 1'b1; pc_sel = br_taken; retire = 1'b1; end
                    K_FENCE:  begin pc_we = 1'b1; retire = 1'b1; end
                    K_LOAD, K_STORE: state_d = S_MEM;
                    default:  state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (kind_q == K_STORE);
                // An ack on the final counted cycle takes priority over the timeout.
                if (dmem_ack) begin
                    if (kind_q == K_STORE) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_inc == TMO_LIMIT) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_DMEM;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                pc_sel = (kind_q == K_JUMP);
                if (kind_q == K_LOAD)      wb_sel = 2'd1;
                else if (kind_q == K_JUMP) wb_sel = 2'd2;
            end
            S_TRAP: begin
                trap = 1'b1;
                if (trap_clr) begin
                    state_d = S_IDLE;
                    cause_d = 2'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Instruction boundary: en decides whether to fetch again or park.
        if (retire) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = en ? S_IF : S_IDLE;
        end
    end

    assign imm_sel    = (state_q == S_EX || state_q == S_MEM || state_q == S_WB) ? imm_q : 3'd0;
    assign retire_cnt = cnt_q;
    assign trap_cause = cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_ALU;
            imm_q   <= 3'd0;
            tmo_q   <= '0;
            cause_q <= 2'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            imm_q   <= imm_d;
            tmo_q   <= tmo_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_core_seq_ctrl
// Randomized instruction-level bench for core_seq_ctrl with an expected-output
// queue built per instruction from the sequencing rules.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_core_seq_ctrl;

    localparam int TMO = 4;
    localparam int CW  = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, br_taken = 1'b0;
    logic imem_valid = 1'b0, dmem_ack = 1'b0, trap_clr = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, retire, trap;
    logic [2:0] imm_sel;
    logic [1:0] wb_sel, trap_cause;
    logic [CW-1:0] retire_cnt;

    core_seq_ctrl #(.TIMEOUT_CYC(TMO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .opcode(opcode), .br_taken(br_taken),
        .imem_req(imem_req), .imem_valid(imem_valid), .ir_we(ir_we), .imm_sel(imm_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .rf_we(rf_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .retire(retire),
        .retire_cnt(retire_cnt), .trap(trap), .trap_cause(trap_cause), .trap_clr(trap_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          imem_req;
        logic          ir_we;
        logic [2:0]    imm_sel;
        logic          dmem_req;
        logic          dmem_we;
        logic          rf_we;
        logic [1:0]    wb_sel;
        logic          pc_we;
        logic          pc_sel;
        logic          retire;
        logic [CW-1:0] cnt;
        logic          trap;
        logic [1:0]    cause;
    } obs_t;

    obs_t act;
    assign act = {imem_req, ir_we, imm_sel, dmem_req, dmem_we, rf_we, wb_sel,
                  pc_we, pc_sel, retire, retire_cnt, trap, trap_cause};

    obs_t expq[$];
    int   n_cmp = 0, n_bad = 0;
    int   mcnt = 0;
    logic in_if = 1'b0;

    int   tick = 0, n_ret = 0, ret_tick = 0, n_rf = 0, n_dm = 0, n_ir = 0;
    logic last_pcsel = 1'b0;
    logic [1:0] seen_cause = 2'd0;

    always @(posedge clk) tick <= tick + 1;

    always @(negedge clk) begin
        if (retire) begin n_ret++; ret_tick = tick; last_pcsel = pc_sel; end
        if (rf_we)    n_rf++;
        if (dmem_req) n_dm++;
        if (ir_we)    n_ir++;
        if (trap)     seen_cause = trap_cause;
    end

    always @(negedge clk) begin
        obs_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL cycle t=%0t op=%b: got %h required %h", $time, opcode, act, e);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, expv);
        end
    endtask

    function automatic obs_t z();
        obs_t o = '0;
        o.cnt = CW'(mcnt);
        return o;
    endfunction

    function automatic int imm_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: return 1;
            7'b0100011:                         return 2;
            7'b1100011:                         return 3;
            7'b0110111, 7'b0010111:             return 4;
            7'b1101111:                         return 5;
            7'b0110011, 7'b0001111:             return 0;
            default:                            return -1;
        endcase
    endfunction

    task automatic step(input obs_t e);
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        mcnt = (mcnt + 1) % (1 << CW);
    endtask

    task automatic bring();
        obs_t e;
        int   w;
        if (!in_if) begin
            w = $urandom_range(0, 2);
            for (int k = 0; k < w; k++) begin
                en = 1'b0; imem_valid = 1'($urandom); dmem_ack = 1'($urandom);
                e = z(); step(e);
            end
            en = 1'b1; e = z(); step(e);
            in_if = 1'b1;
        end
    endtask

    task automatic do_trap(input int cause);
        obs_t e;
        int   w = $urandom_range(0, 3);
        for (int k = 0; k <= w; k++) begin
            trap_clr = (k == w);
            en = 1'($urandom);
            e = z(); e.trap = 1'b1; e.cause = 2'(cause);
            step(e);
        end
        trap_clr = 1'b0;
        in_if = 1'b0;
    endtask

    // One instruction starting with the DUT in IF; fw/aw are wait cycles.
    task automatic do_instr(input logic [6:0] op, input int fw, input logic br,
                            input int aw, input logic en_next);
        obs_t e;
        int   im;
        logic is_ls, is_st, is_jmp;
        opcode = op; br_taken = br;
        im = imm_of(op);
        is_st  = (op == OP_STORE);
        is_ls  = (op == OP_LOAD) || is_st;
        is_jmp = (op == OP_JAL) || (op == OP_JALR);
        for (int k = 1; k <= fw && k <= TMO; k++) begin
            imem_valid = 1'b0; en = 1'($urandom);
            e = z(); e.imem_req = 1'b1; step(e);
        end
        if (fw >= TMO) begin do_trap(2); return; end
        imem_valid = 1'b1; en = 1'($urandom);
        e = z(); e.imem_req = 1'b1; e.ir_we = 1'b1; step(e);
        imem_valid = 1'($urandom); en = 1'($urandom);
        e = z(); step(e);
        if (im < 0) begin do_trap(1); return; end
        e = z(); e.imm_sel = 3'(im);
        if (op == OP_BRANCH || op == OP_FENCE) begin
            e.pc_we = 1'b1; e.retire = 1'b1;
            e.pc_sel = (op == OP_BRANCH) ? br : 1'b0;
            en = en_next; step(e); bump(); in_if = en_next;
            return;
        end
        en = 1'($urandom); dmem_ack = 1'($urandom); step(e);
        if (is_ls) begin
            for (int k = 1; k <= aw && k <= TMO; k++) begin
                dmem_ack = 1'b0; en = 1'($urandom);
                e = z(); e.imm_sel = 3'(im); e.dmem_req = 1'b1; e.dmem_we = is_st; step(e);
            end
            if (aw >= TMO) begin do_trap(3); return; end
            dmem_ack = 1'b1;
            e = z(); e.imm_sel = 3'(im); e.dmem_req = 1'b1; e.dmem_we = is_st;
            if (is_st) begin
                e.pc_we = 1'b1; e.retire = 1'b1;
                en = en_next; step(e); bump(); dmem_ack = 1'b0; in_if = en_next;
                return;
            end
            en = 1'($urandom); step(e); dmem_ack = 1'b0;
        end
        e = z(); e.imm_sel = 3'(im);
        e.rf_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        e.wb_sel = (op == OP_LOAD) ? 2'd1 : (is_jmp ? 2'd2 : 2'd0);
        e.pc_sel = is_jmp;
        en = en_next; step(e); bump(); in_if = en_next;
    endtask

    logic [6:0] ops [12] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0100011,
                             7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                             7'b0110011, 7'b0001111, 7'b1110011, 7'b1111111};

    function automatic int rnd_wait();
        int r = $urandom_range(0, 9);
        if (r < 6) return 0;
        if (r < 9) return $urandom_range(1, TMO - 1);
        return TMO;
    endfunction

    initial begin
        int t0, r0, d0, i0;
        obs_t e;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_outputs", 32'(act), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // OP from IDLE: 4-cycle latency, count 1
        bring(); t0 = tick;
        do_instr(OP_OP, 0, 1'b0, 0, 1'b1);
        chk("op_retire_cnt", 32'(retire_cnt), 32'd1);
        chk("op_latency", 32'(ret_tick - t0), 32'd3);

        // LOAD with 3-cycle ack delay: 4 MEM cycles, 8 total
        t0 = tick; d0 = n_dm;
        do_instr(OP_LOAD, 0, 1'b0, 3, 1'b1);
        chk("load_mem_cycles", 32'(n_dm - d0), 32'd4);
        chk("load_latency", 32'(ret_tick - t0), 32'd7);
        chk("load_retire_cnt", 32'(retire_cnt), 32'd2);

        // Branches taken / not taken: 3 cycles, no register write
        r0 = n_rf; t0 = tick;
        do_instr(OP_BRANCH, 0, 1'b1, 0, 1'b1);
        chk("br_taken_latency", 32'(ret_tick - t0), 32'd2);
        chk("br_taken_pcsel", 32'(last_pcsel), 32'd1);
        do_instr(OP_BRANCH, 0, 1'b0, 0, 1'b1);
        chk("br_not_taken_pcsel", 32'(last_pcsel), 32'd0);
        chk("br_no_rf_we", 32'(n_rf - r0), 32'd0);

        // SYSTEM opcode traps as illegal, count unchanged, cause cleared on exit
        do_instr(OP_SYS, 0, 1'b0, 0, 1'b1);
        chk("illegal_cause", 32'(seen_cause), 32'd1);
        chk("illegal_cnt_held", 32'(retire_cnt), 32'd4);
        chk("cause_cleared", 32'(trap_cause), 32'd0);

        // Fetch timeout, then valid on the final counted cycle
        bring();
        do_instr(OP_OP, TMO, 1'b0, 0, 1'b1);
        chk("imem_timeout_cause", 32'(seen_cause), 32'd2);
        bring(); i0 = n_ir;
        do_instr(OP_OP, TMO - 1, 1'b0, 0, 1'b1);
        chk("late_valid_ir_we", 32'(n_ir - i0), 32'd1);
        chk("late_valid_cnt", 32'(retire_cnt), 32'd5);

        // Randomized instruction stream (counter wraps at 4 bits)
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            op = ops[$urandom_range(0, 11)];
            bring();
            do_instr(op, rnd_wait(), 1'($urandom), rnd_wait(), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset during a MEM access
        bring();
        while (mcnt == 0) begin
            do_instr(OP_OP, 0, 1'b0, 0, 1'b1);
        end
        opcode = OP_STORE; imem_valid = 1'b1; dmem_ack = 1'b0; en = 1'b1;
        e = z(); e.imem_req = 1'b1; e.ir_we = 1'b1; step(e);
        e = z(); step(e);
        e = z(); e.imm_sel = 3'd2; step(e);
        e = z(); e.imm_sel = 3'd2; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
        expq.push_back(e);
        @(negedge clk); #2;
        chk("mem_req_before_reset", 32'(dmem_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("reset_drops_dmem_req", 32'(dmem_req), 32'd0);
        chk("reset_clears_cnt", 32'(retire_cnt), 32'd0);
        chk("reset_no_trap", 32'(trap), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; mcnt = 0; en = 1'b0; in_if = 1'b0;
        e = z(); step(e);
        e = z(); step(e);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core. Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives the instruction and data memory handshakes, the immediate-type select for the immediate generator, register-file and PC write enables, and traps on illegal opcodes and memory timeouts.
- Sits between the memory interfaces and the datapath (PC, IR, immediate generator, ALU, register file).

Parameters:
- TIMEOUT_CYC, 16, max cycles to wait for imem_valid/dmem_ack before trapping; 2..255.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  run enable, sampled in IDLE and at each instruction boundary
- opcode  input  7  IR[6:0], valid from ID onward
- br_taken  input  1  ALU compare result, sampled in EX
- imem_req  output  1  instruction fetch request
- imem_valid  input  1  fetch data valid
- ir_we  output  1  latch instruction register
- imm_sel  output  3  0 none, 1 I, 2 S, 3 B, 4 U, 5 J
- dmem_req  output  1  data access request
- dmem_we  output  1  1 store, 0 load
- dmem_ack  input  1  data access complete
- rf_we  output  1  register-file write enable
- wb_sel  output  2  0 ALU, 1 memory, 2 PC+4
- pc_we  output  1  PC update pulse
- pc_sel  output  1  0 PC+4, 1 target
- retire  output  1  instruction-complete pulse
- retire_cnt  output  CNT_WIDTH  retired-instruction count
- trap  output  1  trap active
- trap_cause  output  2  1 illegal, 2 imem timeout, 3 dmem timeout
- trap_clr  input  1  leave TRAP

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE, clears retire_cnt, trap_cause and the timeout counter, and drives every output to 0 immediately. Any in-flight handshake is abandoned.
- States: IDLE, IF, ID, EX, MEM, WB, TRAP.
- IDLE:
  - all outputs 0;
  - en=1 -> IF.
- IF:
  - imem_req=1;
  - imem_valid=1 -> ir_we=1 (same cycle), -> ID;
  - else the timeout counter increments; when it reaches TIMEOUT_CYC -> TRAP, cause 2.
- ID:
  - decode opcode and register imm_sel (held until the next IF): LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; LUI 0110111, AUIPC 0010111 -> U; JAL 1101111 -> J; OP 0110011, FENCE 0001111 -> none;
  - any other opcode, including SYSTEM -> TRAP, cause 1;
  - else -> EX.
- EX:
  - BRANCH: pc_we=1, pc_sel=br_taken, retire=1 -> boundary;
  - FENCE: pc_we=1, pc_sel=0, retire=1 -> boundary;
  - LOAD/STORE -> MEM;
  - all others -> WB.
- MEM:
  - dmem_req=1, dmem_we=(STORE), both held stable until dmem_ack;
  - on ack: STORE -> pc_we=1, pc_sel=0, retire=1 -> boundary; LOAD -> WB;
  - timeout as in IF -> TRAP, cause 3.
- WB:
  - rf_we=1, pc_we=1, retire=1;
  - wb_sel: LOAD 1; JAL/JALR 2; else 0;
  - pc_sel: 1 for JAL/JALR, else 0;
  - -> boundary.
- Boundary: en=1 -> IF, en=0 -> IDLE.
- Timeout counter clears on every entry to IF or MEM. An ack arriving on the same cycle the count reaches TIMEOUT_CYC wins (no trap).
- rf_we, pc_we, retire and ir_we are exactly one-cycle pulses.
- retire_cnt increments on each retire and wraps to 0 past all-ones.
- TRAP:
  - trap=1, trap_cause held, all other strobes 0, retire_cnt not incremented;
  - trap_clr=1 -> IDLE and trap_cause cleared.
- Latencies with zero-wait memory (IF entry to retire inclusive): OP/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH/FENCE 3.
- en deasserted mid-instruction has no effect until the boundary.

Test Plan:
- Reset then en=1, imem_valid tied 1, opcode 0110011 -> states IF,ID,EX,WB; rf_we/pc_we/retire pulse in cycle 4 with wb_sel=0, pc_sel=0; retire_cnt=1.
- LOAD 0000011 with dmem_ack delayed 3 cycles -> imm_sel=1, dmem_req=1 and dmem_we=0 held 4 cycles; WB with wb_sel=1; total 8 cycles.
- BRANCH 1100011, br_taken=1, then br_taken=0 -> imm_sel=3; pc_we in EX with pc_sel=1 then 0; rf_we never asserted; 3 cycles each.
- Opcode 1110011 -> TRAP, trap=1, cause 1, retire_cnt unchanged; trap_clr -> IDLE, trap_cause=0.
- imem_valid held 0 with TIMEOUT_CYC=4 -> TRAP cause 2 after 4 IF cycles. Repeat with valid arriving on the 4th cycle -> no trap, ir_we pulses.
- rst_n low during MEM with dmem_req=1 -> dmem_req drops to 0 the same cycle, state IDLE, retire_cnt=0.
